// File: rtl/dlx_hazard_pkg.sv
// Shared types and constants for the DLX pipeline hazard controller.
package dlx_hazard_pkg;

  localparam int LCNT_W   = 3;
  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hz_state_t;

  typedef struct packed {
    hz_state_t           state;
    logic [LCNT_W-1:0]   lcnt;
  } hz_dbg_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Three free-running 32-bit event counters for hazard_ctrl (built only with HAZARD_PERF_CNT_EN).
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_evt,
  input  logic        flush_evt,
  input  logic        wait_evt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_wait_cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (stall_evt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_evt) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (wait_evt)  perf_wait_cnt  <= perf_wait_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/bubble sequencing for the IF, ID and EX registers of the 5-stage DLX core.
// Optional performance counters are compiled in with HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import dlx_hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 2,
  parameter int REG_W             = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs1_ID,
  input  logic [REG_W-1:0] Rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic             d_load_enable_EX,
  input  logic [REG_W-1:0] Rd_EX,
  input  logic             pc_cmd_EX,
  input  logic             d_req_MEM,
  input  logic             d_ready_MEM,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             stall_EX,
  output logic             flush_ID,
  output logic             bubble_EX,
  output logic             busy,
  output hz_dbg_t          dbg
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt,
  output logic [31:0]      perf_wait_cnt
`endif
);

  localparam logic [LCNT_W-1:0] LCNT_INIT = LCNT_W'(LOAD_STALL_CYCLES - 1);

  hz_state_t         state, state_nxt;
  logic [LCNT_W-1:0] lcnt, lcnt_nxt;
  logic              mem_hold, lu_hit;

  assign mem_hold = d_req_MEM & ~d_ready_MEM;
  assign lu_hit   = d_load_enable_EX & (Rd_EX != REG_W'(REG_ZERO)) &
                    ((use_rs1_ID & (Rs1_ID == Rd_EX)) | (use_rs2_ID & (Rs2_ID == Rd_EX)));

  // MEM_WAIT shares the RUN decision: a held access keeps freezing, a release
  // acts on any pending branch or load-use in the same cycle.
  always_comb begin
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    flush_ID  = 1'b0;
    bubble_EX = 1'b0;
    state_nxt = state;
    lcnt_nxt  = lcnt;
    case (state)
      LOAD_STALL: begin
        stall_IF = 1'b1;
        stall_ID = 1'b1;
        if (mem_hold) begin
          stall_EX = 1'b1;
        end else begin
          bubble_EX = 1'b1;
          if (lcnt == LCNT_W'(1)) begin
            state_nxt = RUN;
            lcnt_nxt  = '0;
          end else begin
            lcnt_nxt = lcnt - LCNT_W'(1);
          end
        end
      end
      default: begin
        if (mem_hold) begin
          stall_IF  = 1'b1;
          stall_ID  = 1'b1;
          stall_EX  = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (pc_cmd_EX) begin
          flush_ID  = 1'b1;
          bubble_EX = 1'b1;
          state_nxt = RUN;
        end else if (lu_hit) begin
          stall_IF  = 1'b1;
          stall_ID  = 1'b1;
          bubble_EX = 1'b1;
          lcnt_nxt  = LCNT_INIT;
          state_nxt = (LOAD_STALL_CYCLES == 1) ? RUN : LOAD_STALL;
        end else begin
          state_nxt = RUN;
        end
      end
    endcase
    if (reset) begin
      stall_IF  = 1'b0;
      stall_ID  = 1'b0;
      stall_EX  = 1'b0;
      flush_ID  = 1'b0;
      bubble_EX = 1'b0;
    end
  end

  assign busy      = ~reset & (state != RUN);
  assign dbg.state = state;
  assign dbg.lcnt  = lcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      lcnt  <= '0;
    end else begin
      state <= state_nxt;
      lcnt  <= lcnt_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf (
    .clk            (clk),
    .reset          (reset),
    .stall_evt      (bubble_EX & ~pc_cmd_EX),
    .flush_evt      (flush_ID),
    .wait_evt       (stall_EX),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
  );
`endif

endmodule
